// File: rtl/ferc_shift_out_pkg.sv
// ferc_shift_out_pkg: shared relay chain width and relay bit positions for upstream control logic
package ferc_shift_out_pkg;
  localparam int FERC_WIDTH = 16;
  localparam int FERC_BIT_ATT_10DB = 0;
  localparam int FERC_BIT_ATT_20DB = 1;
  localparam int FERC_BIT_ATT_40DB = 2;
  localparam int FERC_BIT_LNA_BYP = 3;
  localparam int FERC_BIT_FILT_LO = 4;
  localparam int FERC_BIT_FILT_HI = 5;
  localparam int FERC_BIT_CAL_EN = 6;
  localparam int FERC_BIT_TERM_50 = 7;
endpackage

// File: rtl/ferc_shift_out.sv
// ferc_shift_out: serializes relay words MSB first onto the front-end relay shift-register chain
module ferc_shift_out
  import ferc_shift_out_pkg::*;
#(
  parameter int WIDTH = FERC_WIDTH,
  parameter int HALF_PERIOD = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input_tdata,
  input  logic             input_tvalid,
  output logic             input_tready,
  output logic             ferc_dat,
  output logic             ferc_clk,
  output logic             ferc_lat,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int PW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  state_t state;
  logic [PW-1:0] phase;
  logic [BW-1:0] bits;
  logic [WIDTH-1:0] sreg, nxt;
  logic phase_end;
  assign phase_end = phase == PW'(HALF_PERIOD - 1);
  assign nxt = sreg << 1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      bits <= '0;
      sreg <= '0;
      ferc_dat <= 1'b0;
      ferc_clk <= 1'b0;
      ferc_lat <= 1'b0;
      input_tready <= 1'b1;
      busy <= 1'b0;
    end else begin
      phase <= (state == IDLE || phase_end) ? '0 : phase + 1'b1;
      case (state)
        IDLE: if (input_tvalid && input_tready) begin
          sreg <= input_tdata;
          bits <= BW'(WIDTH);
          ferc_dat <= input_tdata[WIDTH-1];
          input_tready <= 1'b0;
          busy <= 1'b1;
          state <= SHIFT_LO;
        end
        SHIFT_LO: begin
          ferc_dat <= sreg[WIDTH-1];
          if (phase_end) begin
            ferc_clk <= 1'b1;
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: if (phase_end) begin
          sreg <= nxt;
          bits <= bits - 1'b1;
          ferc_clk <= 1'b0;
          // the latch rises together with the final falling shift clock
          ferc_lat <= bits == BW'(1);
          ferc_dat <= bits == BW'(1) ? 1'b0 : nxt[WIDTH-1];
          state <= bits == BW'(1) ? LATCH : SHIFT_LO;
        end
        LATCH: if (phase_end) begin
          ferc_lat <= 1'b0;
          input_tready <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
